// File: rtl/branch_resolve32.sv
// Two-stage branch resolution: S1 latches operands (sign-biased for signed compares),
// a tree comparator plus adders feed S2, which drives all outputs directly.

module magcompare32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        lt,
    output logic        eq,
    output logic        gt
);
    // Heap-indexed tree: leaves 32..63 hold bit j at 32+j, node i merges 2i (low) and 2i+1 (high).
    logic [63:1] lt_n;
    logic [63:1] eq_n;

    genvar j, i;
    generate
        for (j = 0; j < 32; j++) begin : g_leaf
            assign lt_n[32+j] = ~a[j] & b[j];
            assign eq_n[32+j] = ~(a[j] ^ b[j]);
        end
        for (i = 1; i < 32; i++) begin : g_node
            assign lt_n[i] = lt_n[2*i+1] | (eq_n[2*i+1] & lt_n[2*i]);
            assign eq_n[i] = eq_n[2*i+1] & eq_n[2*i];
        end
    endgenerate

    assign lt = lt_n[1];
    assign eq = eq_n[1];
    assign gt = ~lt_n[1] & ~eq_n[1];
endmodule

module branch_resolve32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_imm,
    input  logic        in_pred_taken,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_taken,
    output logic [31:0] out_target,
    output logic [31:0] out_next_pc,
    output logic        out_mispredict,
    output logic        out_illegal,
    output logic        out_misaligned,
    output logic [15:0] mispredict_count
);
    logic        s1_valid;
    logic [2:0]  s1_funct3;
    logic [31:0] s1_pc, s1_imm, s1_a, s1_b;
    logic        s1_pred;

    logic        cmp_lt, cmp_eq, cmp_gt;
    logic        s2_accept;
    logic        cond_taken, cond_illegal;
    logic [31:0] s1_target, s1_seq;
    logic [31:0] sign_flip;

    assign s2_accept = ~out_valid | out_ready;
    assign in_ready  = ~s1_valid | s2_accept;

    // Flipping bit 31 turns a signed compare into an unsigned one.
    assign sign_flip = {in_funct3[2] & ~in_funct3[1], 31'b0};

    magcompare32 u_cmp (
        .a  (s1_a),
        .b  (s1_b),
        .lt (cmp_lt),
        .eq (cmp_eq),
        .gt (cmp_gt)
    );

    assign s1_target = s1_pc + s1_imm;
    assign s1_seq    = s1_pc + 32'd4;

    always_comb begin
        cond_taken   = 1'b0;
        cond_illegal = 1'b0;
        case (s1_funct3)
            3'b000:         cond_taken = cmp_eq;
            3'b001:         cond_taken = ~cmp_eq;
            3'b100, 3'b110: cond_taken = cmp_lt;
            3'b101, 3'b111: cond_taken = cmp_eq | cmp_gt;
            default:        cond_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid         <= 1'b0;
            s1_funct3        <= 3'b0;
            s1_pc            <= 32'b0;
            s1_imm           <= 32'b0;
            s1_a             <= 32'b0;
            s1_b             <= 32'b0;
            s1_pred          <= 1'b0;
            out_valid        <= 1'b0;
            out_taken        <= 1'b0;
            out_target       <= 32'b0;
            out_next_pc      <= 32'b0;
            out_mispredict   <= 1'b0;
            out_illegal      <= 1'b0;
            out_misaligned   <= 1'b0;
            mispredict_count <= 16'b0;
        end else begin
            // A delivery in the flush cycle still counts.
            if (out_valid && out_ready && out_mispredict && mispredict_count != 16'hffff)
                mispredict_count <= mispredict_count + 16'd1;

            if (flush) begin
                s1_valid  <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                if (s2_accept) begin
                    out_valid <= s1_valid;
                    if (s1_valid) begin
                        out_taken      <= cond_taken;
                        out_target     <= s1_target;
                        out_next_pc    <= cond_taken ? s1_target : s1_seq;
                        out_mispredict <= cond_illegal | (cond_taken != s1_pred);
                        out_illegal    <= cond_illegal;
                        out_misaligned <= cond_taken & (s1_target[1:0] != 2'b00);
                    end
                end
                if (in_ready) begin
                    s1_valid <= in_valid;
                    if (in_valid) begin
                        s1_funct3 <= in_funct3;
                        s1_pc     <= in_pc;
                        s1_imm    <= in_imm;
                        s1_a      <= in_rs1 ^ sign_flip;
                        s1_b      <= in_rs2 ^ sign_flip;
                        s1_pred   <= in_pred_taken;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve32.sv
// Bench for branch_resolve32: directed vector table, hand sequences for stall/flush/
// saturation/reset, and a randomized stream against a queue-based reference model.

module tb_branch_resolve32;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, in_pred_taken;
    logic [2:0]  in_funct3;
    logic [31:0] in_rs1, in_rs2, in_pc, in_imm;
    logic        out_valid, out_ready, out_taken, out_mispredict, out_illegal, out_misaligned;
    logic [31:0] out_target, out_next_pc;
    logic [15:0] mispredict_count;

    branch_resolve32 dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
        .in_pred_taken(in_pred_taken),
        .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
        .out_target(out_target), .out_next_pc(out_next_pc),
        .out_mispredict(out_mispredict), .out_illegal(out_illegal),
        .out_misaligned(out_misaligned), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic [31:0] tgt, nxt;
        logic        misp, ill, mal;
    } res_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rs1, rs2, pc, imm;
        logic        pred;
        res_t        exp;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    res_t q[$];
    int   exp_cnt;
    vec_t tv[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input res_t e);
        chk({nm, ".taken"},  {31'b0, out_taken},      {31'b0, e.taken});
        chk({nm, ".target"}, out_target,              e.tgt);
        chk({nm, ".nextpc"}, out_next_pc,             e.nxt);
        chk({nm, ".misp"},   {31'b0, out_mispredict}, {31'b0, e.misp});
        chk({nm, ".ill"},    {31'b0, out_illegal},    {31'b0, e.ill});
        chk({nm, ".mal"},    {31'b0, out_misaligned}, {31'b0, e.mal});
    endtask

    // Reference: plain signed/unsigned arithmetic on the architectural values.
    function automatic res_t model(input logic [2:0] f3, input logic [31:0] a, b, pc, imm,
                                   input logic pred);
        res_t r;
        logic t;
        t = 1'b0;
        case (f3)
            3'd0: t = (a == b);
            3'd1: t = (a != b);
            3'd4: t = ($signed(a) < $signed(b));
            3'd5: t = !($signed(a) < $signed(b));
            3'd6: t = (a < b);
            3'd7: t = !(a < b);
            default: t = 1'b0;
        endcase
        r.ill   = (f3 == 3'd2) || (f3 == 3'd3);
        r.taken = t;
        r.tgt   = pc + imm;
        r.nxt   = t ? r.tgt : pc + 32'd4;
        r.misp  = r.ill || (t != pred);
        r.mal   = t && (r.tgt[1:0] != 2'b00);
        return r;
    endfunction

    function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] a, b, pc, imm,
                                input logic pred, input logic tk, input logic [31:0] tgt, nxt,
                                input logic misp, ill, mal);
        vec_t v;
        v.f3 = f3; v.rs1 = a; v.rs2 = b; v.pc = pc; v.imm = imm; v.pred = pred;
        v.exp.taken = tk; v.exp.tgt = tgt; v.exp.nxt = nxt;
        v.exp.misp = misp; v.exp.ill = ill; v.exp.mal = mal;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] a, b, pc, imm, input logic pred);
        in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_pc = pc; in_imm = imm; in_pred_taken = pred;
    endtask

    function automatic logic [31:0] pick;
        case ($urandom_range(3))
            0: pick = $urandom;
            1: pick = 32'h8000_0000;
            2: pick = 32'h7fff_ffff;
            default: pick = $urandom_range(7);
        endcase
    endfunction

    res_t snap;
    logic prev_stall;

    task automatic rnd_cycle(input bit drain);
        res_t e;
        logic [31:0] a, b;
        if (drain) begin
            in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        end else begin
            a = pick();
            b = ($urandom_range(1) == 1) ? a : pick();
            drive(3'($urandom_range(7)), a, b, $urandom, ($urandom_range(1) == 1) ? 32'($urandom_range(63)) : $urandom,
                  1'($urandom_range(1)));
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(15) == 0);
        end
        #1;
        if (prev_stall) begin
            chk("rnd_hold_valid", {31'b0, out_valid}, 32'd1);
            chk_out("rnd_hold", snap);
        end
        chk("rnd_cnt", {16'b0, mispredict_count}, exp_cnt);
        chk("rnd_in_ready", {31'b0, in_ready}, {31'b0, !(q.size() == 2 && !out_ready)});
        if (out_valid && out_ready) begin
            chk("rnd_nonempty", {31'b0, q.size() != 0}, 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk_out("rnd_out", e);
                if (e.misp && exp_cnt != 16'hffff) exp_cnt++;
            end
        end
        if (flush) q.delete();
        else if (in_valid && in_ready)
            q.push_back(model(in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken));
        prev_stall = out_valid && !out_ready && !flush;
        snap.taken = out_taken; snap.tgt = out_target; snap.nxt = out_next_pc;
        snap.misp = out_mispredict; snap.ill = out_illegal; snap.mal = out_misaligned;
        tick;
    endtask

    initial begin
        int sent, recv, stalls, seen;
        logic [31:0] held;
        logic        held_ok;

        tv[0]  = mk(3'b100, 32'hffff_ffff, 32'h1, 32'h100, 32'h20, 0, 1, 32'h120, 32'h120, 1, 0, 0);
        tv[1]  = mk(3'b110, 32'hffff_ffff, 32'h1, 32'h100, 32'h20, 0, 0, 32'h120, 32'h104, 0, 0, 0);
        tv[2]  = mk(3'b111, 32'hffff_ffff, 32'h1, 32'h100, 32'h20, 1, 1, 32'h120, 32'h120, 0, 0, 0);
        tv[3]  = mk(3'b000, 32'h8000_0000, 32'h8000_0000, 32'h200, 32'h8, 1, 1, 32'h208, 32'h208, 0, 0, 0);
        tv[4]  = mk(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h200, 32'h8, 1, 0, 32'h208, 32'h204, 1, 0, 0);
        tv[5]  = mk(3'b010, 32'h5, 32'h5, 32'h300, 32'h10, 0, 0, 32'h310, 32'h304, 1, 1, 0);
        tv[6]  = mk(3'b011, 32'h5, 32'h5, 32'h300, 32'h10, 1, 0, 32'h310, 32'h304, 1, 1, 0);
        tv[7]  = mk(3'b000, 32'h7, 32'h7, 32'hffff_fff0, 32'h20, 1, 1, 32'h10, 32'h10, 0, 0, 0);
        tv[8]  = mk(3'b000, 32'h9, 32'h9, 32'h400, 32'h2, 1, 1, 32'h402, 32'h402, 0, 0, 1);
        tv[9]  = mk(3'b101, 32'h1, 32'hffff_ffff, 32'h500, 32'hffff_fff0, 0, 1, 32'h4f0, 32'h4f0, 1, 0, 0);
        tv[10] = mk(3'b101, 32'h8000_0000, 32'h7fff_ffff, 32'h500, 32'h40, 1, 0, 32'h540, 32'h504, 1, 0, 0);
        tv[11] = mk(3'b001, 32'h3, 32'h3, 32'h600, 32'h6, 0, 0, 32'h606, 32'h604, 0, 0, 0);

        drive(3'b0, 0, 0, 0, 0, 0);
        do_reset;
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_target",    out_target,         32'd0);
        chk("rst_nextpc",    out_next_pc,        32'd0);
        chk("rst_cnt",       {16'b0, mispredict_count}, 32'd0);

        // Directed vectors, one at a time, checking the two-edge latency.
        for (int i = 0; i < 12; i++) begin
            drive(tv[i].f3, tv[i].rs1, tv[i].rs2, tv[i].pc, tv[i].imm, tv[i].pred);
            in_valid = 1'b1; out_ready = 1'b1;
            tick;
            in_valid = 1'b0;
            chk($sformatf("vec%0d_lat1", i), {31'b0, out_valid}, 32'd0);
            tick;
            chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
            chk_out($sformatf("vec%0d", i), tv[i].exp);
            tick;
            if (i == 0) chk("vec0_cnt", {16'b0, mispredict_count}, 32'd1);
        end
        chk("vec_cnt_total", {16'b0, mispredict_count}, 32'd6);

        // Backpressure: 4 BEQ entries, out_ready low on cycles 2..5.
        do_reset;
        sent = 0; recv = 0; stalls = 0; held_ok = 1'b0; held = 0;
        for (int c = 0; c < 16; c++) begin
            out_ready = !(c >= 2 && c <= 5);
            in_valid  = (sent < 4);
            drive(3'b000, 32'h1, 32'h1, 32'h1000 + 32'(sent) * 32'h10, 32'h8, 1);
            #1;
            if (held_ok) chk("bp_hold", out_next_pc, held);
            if (!in_ready) stalls++;
            if (out_valid && out_ready) begin
                chk($sformatf("bp_order%0d", recv), out_next_pc, 32'h1008 + 32'(recv) * 32'h10);
                recv++;
            end
            held_ok = out_valid && !out_ready;
            held = out_next_pc;
            if (in_valid && in_ready) sent++;
            tick;
        end
        in_valid = 1'b0;
        chk("bp_recv", recv, 32'd4);
        chk("bp_stalled", {31'b0, stalls != 0}, 32'd1);

        // Flush with both stages full; the head is illegal so its delivery bumps the count.
        do_reset;
        out_ready = 1'b0; in_valid = 1'b1;
        drive(3'b010, 0, 0, 32'h2000, 32'h4, 0);
        tick;
        drive(3'b000, 0, 0, 32'h3000, 32'h4, 1);
        tick;
        chk("fl_full_in_ready", {31'b0, in_ready}, 32'd0);
        drive(3'b000, 0, 0, 32'h4000, 32'h4, 1);
        flush = 1'b1; out_ready = 1'b1;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_in_ready",  {31'b0, in_ready},  32'd1);
        chk("fl_cnt",       {16'b0, mispredict_count}, 32'd1);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) seen++;
            tick;
        end
        chk("fl_no_ghost", seen, 32'd0);

        // Randomized stream against the queue model, then drain.
        do_reset;
        q.delete(); exp_cnt = 0; prev_stall = 1'b0;
        for (int c = 0; c < 800; c++) rnd_cycle(1'b0);
        for (int c = 0; c < 4; c++) rnd_cycle(1'b1);
        chk("rnd_drained", q.size(), 32'd0);

        // Counter saturation with a continuous stream of illegal branches.
        do_reset;
        drive(3'b010, 0, 0, 32'h10, 32'h4, 0);
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (65535) tick;
        chk("sat_below", {16'b0, mispredict_count}, 32'd65533);
        repeat (10) tick;
        chk("sat_cnt", {16'b0, mispredict_count}, 32'h0000_ffff);

        // Reset mid-stream, then the first accept right after release.
        reset = 1'b1;
        tick;
        chk("mrst_cnt",       {16'b0, mispredict_count}, 32'd0);
        chk("mrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst_in_ready",  {31'b0, in_ready},  32'd1);
        reset = 1'b0;
        drive(3'b000, 32'h5, 32'h5, 32'h40, 32'h8, 1);
        tick;
        in_valid = 1'b0;
        tick;
        chk("mrst_first_valid", {31'b0, out_valid}, 32'd1);
        chk("mrst_first_next",  out_next_pc, 32'h48);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
